pool_upsampler: RTL

- Inverse of the 2x2 max-pooling stage: accepts a framed, pooled feature-map stream and emits a nearest-neighbour 2x upsampled stream using the same framing signals.
- Each input pixel is replicated 2x horizontally, and each input line 2x vertically.
- Sits on the decoder and backward side of the CNN pipeline, where pooled maps are expanded back to pre-pool resolution.
- Input is back-pressured with in_ready because the output rate is 4x the input pixel rate.

---
 rtl/cnn_stream_pkg.sv | 22 ++
 rtl/upsample_line_buf.sv | 33 +++
 rtl/pool_upsampler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
//------------------------------------------------------------------------------
// cnn_stream_pkg : shared types for the CNN pixel-stream blocks
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package cnn_stream_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW_A = 2'd1,
        ROW_B = 2'd2
    } up_state_t;

endpackage

`default_nettype wire

// File: rtl/upsample_line_buf.sv
//------------------------------------------------------------------------------
// upsample_line_buf : one-line pixel store, one write port, registered read
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module upsample_line_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 12,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are never reset: every entry is rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/pool_upsampler.sv
//------------------------------------------------------------------------------
// pool_upsampler : 2x nearest-neighbour upsampler for a framed pooled stream
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pool_upsampler #(
    parameter int DATA_W = cnn_stream_pkg::DATA_W,
    parameter int IN_W   = 12,
    parameter int IN_H   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     frame_start_in,
    input  logic                     line_start_in,
    input  logic                     frame_end_in,
    input  logic signed [DATA_W-1:0] sig_layer,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] up_layer,
    output logic                     valid,
    output logic                     frame_start_out,
    output logic                     line_start_out,
    output logic                     frame_end_out,
    output logic                     err
);

    import cnn_stream_pkg::*;

    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IN_H - 1);

    up_state_t   r_state, w_state_nxt;
    logic        r_p, w_p_nxt;
    logic [CW-1:0] r_col, w_col_nxt, w_acc_col, w_wr_addr, w_rd_addr;
    logic [RW-1:0] r_row, w_row_nxt, w_acc_row;
    logic        w_accept, w_take, w_wr_en;
    logic        w_rdy_nxt, w_valid_nxt, w_fs_nxt, w_ls_nxt, w_fe_nxt, w_err_nxt;
    logic signed [DATA_W-1:0] w_up_nxt;
    logic [DATA_W-1:0] w_rd_data;

    upsample_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_W),
        .AW     (CW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (sig_layer),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_up_nxt    = up_layer;
        w_valid_nxt = 1'b0;
        w_fs_nxt    = 1'b0;
        w_ls_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        w_err_nxt   = err;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_col;
        w_rd_addr   = '0;

        // A frame_start_in pixel always lands at (0,0), even as a mid-frame restart.
        w_accept  = ena && in_ready;
        w_acc_col = frame_start_in ? '0 : r_col;
        w_acc_row = frame_start_in ? '0 : r_row;
        w_take    = w_accept && (frame_start_in || (r_state == ROW_A));

        if (w_accept && !w_take) begin
            w_err_nxt = 1'b1;
        end

        if (w_take) begin
            w_wr_en     = 1'b1;
            w_wr_addr   = w_acc_col;
            w_up_nxt    = sig_layer;
            w_valid_nxt = 1'b1;
            w_ls_nxt    = (w_acc_col == '0);
            w_fs_nxt    = (w_acc_col == '0) && (w_acc_row == '0);
            w_state_nxt = ROW_A;
            w_p_nxt     = 1'b1;
            w_col_nxt   = w_acc_col;
            w_row_nxt   = w_acc_row;
            if ((line_start_in != (w_acc_col == '0)) ||
                (frame_end_in != ((w_acc_col == C_COL_LAST) && (w_acc_row == C_ROW_LAST))) ||
                (frame_start_in && (r_state != IDLE))) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                ROW_A: begin
                    if (r_p) begin
                        w_valid_nxt = 1'b1;
                        w_p_nxt     = 1'b0;
                        if (r_col == C_COL_LAST) begin
                            w_state_nxt = ROW_B;
                            w_col_nxt   = '0;
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end
                end
                ROW_B: begin
                    w_up_nxt    = w_rd_data;
                    w_valid_nxt = 1'b1;
                    w_ls_nxt    = (r_col == '0) && !r_p;
                    w_fe_nxt    = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST) && r_p;
                    if (r_p) begin
                        w_p_nxt = 1'b0;
                        if (r_col == C_COL_LAST) begin
                            w_col_nxt = '0;
                            if (r_row == C_ROW_LAST) begin
                                w_state_nxt = IDLE;
                                w_row_nxt   = '0;
                            end else begin
                                w_state_nxt = ROW_A;
                                w_row_nxt   = r_row + RW'(1);
                            end
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end else begin
                        w_p_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Read one step ahead: rd_data must already hold the pixel replayed next cycle.
        if (r_state == ROW_B) begin
            if (!r_p) begin
                w_rd_addr = r_col;
            end else if (r_col != C_COL_LAST) begin
                w_rd_addr = r_col + CW'(1);
            end
        end

        w_rdy_nxt = (w_state_nxt == IDLE) || ((w_state_nxt == ROW_A) && !w_p_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_p             <= 1'b0;
            r_col           <= '0;
            r_row           <= '0;
            in_ready        <= 1'b0;
            up_layer        <= '0;
            valid           <= 1'b0;
            frame_start_out <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
            err             <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_p             <= w_p_nxt;
            r_col           <= w_col_nxt;
            r_row           <= w_row_nxt;
            in_ready        <= w_rdy_nxt;
            up_layer        <= w_up_nxt;
            valid           <= w_valid_nxt;
            frame_start_out <= w_fs_nxt;
            line_start_out  <= w_ls_nxt;
            frame_end_out   <= w_fe_nxt;
            err             <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire
